// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default operand width, iteration-counter width helper.
package mul_pkg;

    localparam int MUL_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter must reach WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mul32_seq_if.sv
// Start/busy/done handshake bundle between controller and multiplier.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored by the slave while it is busy.
//
// Signals: start, a, b (and sgn when MUL32_SIGNED_EN is defined) flow master->slave;
// busy, done, p flow slave->master.
interface mul32_seq_if #(
    parameter int WIDTH = mul_pkg::MUL_W
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
`ifdef MUL32_SIGNED_EN
    logic                 sgn;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

`ifdef MUL32_SIGNED_EN
    modport master (output start, output a, output b, output sgn,
                    input  busy,  input  done, input  p);
    modport slave  (input  start, input  a, input  b, input  sgn,
                    output busy,  output done, output p);
`else
    modport master (output start, output a, output b,
                    input  busy,  input  done, input  p);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output p);
`endif

endinterface

// File: rtl/mul_step.sv
// One shift-and-add multiplier iteration: (WIDTH+1)-bit lookahead add, then shift right.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: i_hi/i_lo/i_ma current partial product and multiplicand; o_hi/o_lo next partial product.
// With MUL32_SIGNED_EN: i_signed_mode selects sign-extended arithmetic, i_last marks the final
// iteration, where the multiplier's sign bit carries negative weight.
module mul_step #(
    parameter int WIDTH = mul_pkg::MUL_W
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_ma,
`ifdef MUL32_SIGNED_EN
    input  logic             i_signed_mode,
    input  logic             i_last,
`endif
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic             w_ext_hi;
    logic             w_ext_ma;
    logic             w_neg;
    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_y;
    logic [WIDTH:0]   w_g;
    logic [WIDTH:0]   w_p;
    logic [WIDTH:0]   w_c;
    logic [WIDTH:0]   w_sum;

`ifdef MUL32_SIGNED_EN
    assign w_ext_hi = i_signed_mode & i_hi[WIDTH-1];
    assign w_ext_ma = i_signed_mode & i_ma[WIDTH-1];
    // The multiplier MSB weighs -2^(WIDTH-1): subtract ma on the final step.
    assign w_neg    = i_signed_mode & i_last & i_lo[0];
`else
    assign w_ext_hi = 1'b0;
    assign w_ext_ma = 1'b0;
    assign w_neg    = 1'b0;
`endif

    assign w_x = {w_ext_hi, i_hi};
    // Subtraction is ~y + 1; the +1 enters as carry-in.
    assign w_y = i_lo[0] ? ({w_ext_ma, i_ma} ^ {(WIDTH+1){w_neg}}) : '0;

    assign w_g = w_x & w_y;
    assign w_p = w_x ^ w_y;

    // Generate/propagate carry recurrence; flattened by synthesis into lookahead logic.
    always_comb begin
        w_c    = '0;
        w_c[0] = w_neg;
        for (int i = 0; i < WIDTH; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign w_sum = w_p ^ w_c;

    assign o_hi = w_sum[WIDTH:1];
    assign o_lo = {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/mul32_seq.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier, one partial-product add per clock.
// Latency: start accepted at edge 0 -> done pulse in the cycle after edge WIDTH (fixed, no early exit).
// Backpressure: start is ignored while busy; accepted back-to-back during the done cycle.
//
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries start/a/b/busy/done/p,
// plus sgn when MUL32_SIGNED_EN is defined (signed two's-complement mode).
module mul32_seq #(
    parameter int WIDTH = mul_pkg::MUL_W
) (
    input  logic         clk,
    input  logic         rst,
    mul32_seq_if.slave   bus
);
    import mul_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef MUL32_SIGNED_EN
    logic r_sgn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sgn <= 1'b0;
        end else if (w_load) begin
            r_sgn <= bus.sgn;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_ma  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
            r_ma  <= bus.a;
            r_hi  <= '0;
            r_lo  <= bus.b;
        end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    mul_step #(
        .WIDTH         (WIDTH)
    ) u_step (
        .i_hi          (r_hi),
        .i_lo          (r_lo),
        .i_ma          (r_ma),
`ifdef MUL32_SIGNED_EN
        .i_signed_mode (r_sgn),
        .i_last        (w_last),
`endif
        .o_hi          (w_hi_nxt),
        .o_lo          (w_lo_nxt)
    );

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.p    = {r_hi, r_lo};

endmodule

// File: tb/tb_mul32_seq.sv
// Directed, table-driven bench for mul32_seq: product values, fixed latency and handshake corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul32_seq;

    typedef struct {
        logic         sgn;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [63:0]  exp_p;
        string        name;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    mul32_seq_if #(.WIDTH(32)) bus ();

    mul32_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive_ops(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.a = a;
        bus.b = b;
`ifdef MUL32_SIGNED_EN
        bus.sgn = s;
`else
        if (s) $display("note: signed vector skipped in unsigned build");
`endif
    endtask

    // Counts remaining busy cycles, then expects the done pulse.
    task automatic wait_done(input string name, input int exp_busy);
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            k++;
            tick();
        end
        check({name, " busy cycles"}, 64'(k), 64'(exp_busy));
        check({name, " done"}, 64'(bus.done), 64'd1);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_p, input string name);
        drive_ops(s, a, b);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(name, 32);
        check({name, " p"}, bus.p, exp_p);
        tick();
        check({name, " done pulse width"}, 64'(bus.done), 64'd0);
        check({name, " p held"}, bus.p, exp_p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int n_busy;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        drive_ops(1'b0, 32'd0, 32'd0);

        vecs.push_back('{1'b0, 32'h7777_7777, 32'hFFFF_FFFF, 64'h7777_7776_8888_8889, "u_7777xFFFF"});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "u_max"});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0,                   "u_zero_a"});
        vecs.push_back('{1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0,                   "u_zero_b"});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 64'h0000_0004_FFFF_FFFB, "u_ffff_x5"});
        vecs.push_back('{1'b0, 32'h0000_0003, 32'hFFFF_FFFE, 64'h0000_0002_FFFF_FFFA, "u_3xfffe"});
        vecs.push_back('{1'b0, 32'h0000_0001, 32'h8000_0000, 64'h0000_0000_8000_0000, "u_1xmsb"});
`ifdef MUL32_SIGNED_EN
        vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, "s_m1x5"});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_minxmin"});
        vecs.push_back('{1'b1, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, "s_3xm2"});
        vecs.push_back('{1'b1, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, "s_7x6"});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, "s_minx1"});
        vecs.push_back('{1'b1, 32'h0000_0001, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, "s_1xmin"});
`endif

        // Reset state.
        tick();
        tick();
        check("reset p", bus.p, 64'h0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle busy", 64'(bus.busy), 64'd0);
        check("idle done", 64'(bus.done), 64'd0);
        check("idle p", bus.p, 64'h0);

        // Vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].name);
        end

        // start re-pulsed while busy with other operands must be ignored.
        drive_ops(1'b0, 32'h7777_7777, 32'hFFFF_FFFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        drive_ops(1'b0, 32'd5, 32'd7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("start_while_busy", 27);
        check("start_while_busy p", bus.p, 64'h7777_7776_8888_8889);
        tick();
        check("start_while_busy idle", 64'(bus.busy), 64'd0);

        // start held through the done cycle: next op starts with no idle cycle.
        drive_ops(1'b0, 32'd2, 32'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("b2b first", 32);
        check("b2b first p", bus.p, 64'd6);
        drive_ops(1'b0, 32'h10, 32'h10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b no idle busy", 64'(bus.busy), 64'd1);
        wait_done("b2b second", 32);
        check("b2b second p", bus.p, 64'h100);
        tick();

        // Reset at iteration 10 discards the result and suppresses done.
        drive_ops(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst p", bus.p, 64'h0);
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
            if (bus.busy === 1'b1) n_busy++;
        end
        check("midrst no done pulse", 64'(n_done), 64'd0);
        check("midrst stays idle", 64'(n_busy), 64'd0);
        run_op(1'b0, 32'd6, 32'd7, 64'd42, "after_rst");

        // rst and start in the same cycle: rst wins.
        drive_ops(1'b0, 32'd9, 32'd9);
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_vs_start busy", 64'(bus.busy), 64'd0);
        check("rst_vs_start p", bus.p, 64'h0);
        tick();
        check("rst_vs_start still idle", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
Name: mul32_seq

Overview:
- Iterative shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial-product add per clock.
- Sits directly downstream of the 32-bit carry-lookahead adder datapath and consumes its sum every iteration. The adder's carry-in is used for two's-complement subtraction in signed mode.
- It is the multicycle MUL unit feeding the execute-stage result mux.
- Start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 32, operand width in bits. Product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request. Sampled only in IDLE or DONE.
- a  input  WIDTH  multiplicand. Latched on accepted start.
- b  input  WIDTH  multiplier. Latched on accepted start.
- sgn  input  1  1 = signed two's-complement operands. Exists only with MUL32_SIGNED_EN.
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when p becomes valid
- p  output  2*WIDTH  product {hi, lo}. Held until the next accepted start.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge.
  - Reset values: state=IDLE, busy=0, done=0, p=0, cnt=0, latched operands=0.
- States:
  - IDLE: busy=0, done=0. start=1 -> load ma=a, hi=0, lo=b, cnt=0, go to RUN.
  - RUN: busy=1. Each cycle performs one step and increments cnt. When cnt==WIDTH-1, step and go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0. start=1 -> load and go to RUN (back-to-back accepted). Otherwise go to IDLE.
- Step (combinational, WIDTH+1-bit add):
  - Unsigned: sum = {0,hi} + (lo[0] ? {0,ma} : 0), ci=0.
  - Signed: sum = {hi[W-1],hi} + (lo[0] ? {ma[W-1],ma} : 0).
  - Signed, last iteration (cnt==WIDTH-1) with lo[0]=1: addend is ~{ma[W-1],ma} with ci=1 (subtract).
  - Update: hi <= sum[WIDTH:1]; lo <= {sum[0], lo[WIDTH-1:1]}.
- Output and latency:
  - p = {hi, lo}. It shows intermediate values while busy and is valid only when done=1 and thereafter until the next load.
  - Latency: start sampled at edge 0 -> done=1 in the cycle after edge WIDTH (WIDTH+1 cycles; 33 for WIDTH=32). This latency is fixed: no early termination, including zero operands.
- Boundary conditions:
  - start while busy: ignored. Operands are not relatched.
  - rst mid-RUN: next cycle is IDLE with p=0. The pending result is discarded and done is never asserted.
  - rst and start in the same cycle: rst wins.
  - Overflow is impossible; the 2*WIDTH product is exact.

Optional Feature:
- Macro: MUL32_SIGNED_EN.
- Defined: sgn port present. sgn is latched with the operands on an accepted start. Signed mode uses the sign-extended step and last-step subtraction above.
- Undefined: no sgn port. Unsigned only; the signed step logic is not generated.

Decomposition:
- Shared package mul_pkg:
  - state enum: IDLE, RUN, DONE
  - MUL_W=32
  - counter width $clog2(WIDTH)
- Sub-module mul_step (combinational):
  - inputs: hi, lo, ma, signed_mode, last
  - outputs: next hi, next lo
  - contains the WIDTH+1-bit carry-lookahead add with carry-in.
- The top holds the FSM, counter and registers.

Test Plan:
- Reset: assert rst 2 cycles -> p=0, busy=0, done=0. Then deassert and hold start=0 -> state stays IDLE.
- Unsigned: a=0x77777777, b=0xFFFFFFFF, start 1 cycle -> busy for 32 cycles, done after 33 cycles, p=0x7777777688888889.
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF -> p=0xFFFFFFFE00000001. Also a=0, b=0x12345678 -> p=0, still 33 cycles.
- Signed (MUL32_SIGNED_EN):
  - sgn=1, a=0xFFFFFFFF, b=0x00000005 -> p=0xFFFFFFFFFFFFFFFB.
  - sgn=1, a=0x80000000, b=0x80000000 -> p=0x4000000000000000.
  - sgn=1, a=3, b=0xFFFFFFFE -> p=0xFFFFFFFFFFFFFFFA.
- Handshake:
  - start re-pulsed while busy with other operands -> ignored; first result is correct.
  - start held high during the DONE cycle -> new operation begins with no IDLE cycle.
- Reset mid-op: rst at iteration 10 -> next cycle busy=0, p=0, and no done pulse. A subsequent start works normally.
